spi_cmd_ctrl: RTL and testbench

Command-protocol controller that sits between the SPI slave byte interface and the board's internal register bus. It sequences each SPI transaction: the first byte after chip-select is a command (direction + address), and the following bytes are written to or read from consecutive registers. It also keeps the slave's transmit byte loaded ahead of every byte slot. Instantiated once, next to the SPI slave, in the same `clk` domain.

---
 rtl/spi_cmd_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: sequences SPI transactions onto the internal register bus.
// The first byte after chip-select is a command: bit 7 selects read (1) or
// write (0), and bits [ADDR_W-1:0] give the start address. The following bytes
// are written to, or read from, the addressed register(s).
// Optional feature macro: SPI_CMD_AUTOINC_EN. When it is defined, the address
// advances after every data byte. When it is undefined, every data byte
// accesses the command address.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transaction; outputs at reset values (xfer_err is kept)
// CMD    | waiting for the command byte; transmit IDLE_FILL
// WRITE  | every received byte is written to addr
// RFETCH | reg_re issued; wait for reg_rdata and load it into byte_send_data
// READ   | read byte loaded; the next received (dummy) byte starts the next fetch

module spi_cmd_ctrl #(
  parameter int          ADDR_W    = 7,
  parameter logic [7:0]  IDLE_FILL = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ssel_active,
  input  logic              byte_received,
  input  logic [7:0]        byte_received_data,
  output logic              byte_send,
  output logic [7:0]        byte_send_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              xfer_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WRITE  = 3'd2,
    S_RFETCH = 3'd3,
    S_READ   = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr, addr_nx, addr_step, cmd_addr;
  logic                byte_send_nx, reg_we_nx, reg_re_nx, busy_nx, xfer_err_nx;
  logic [7:0]          byte_send_data_nx, reg_wdata_nx;
  logic [ADDR_W-1:0]   reg_addr_nx;

  assign cmd_addr = byte_received_data[ADDR_W-1:0];

`ifdef SPI_CMD_AUTOINC_EN
  // Truncation to ADDR_W bits makes the top address wrap to 0.
  assign addr_step = addr + ADDR_W'(1);
`else
  assign addr_step = addr;
`endif

  // State, working address and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      addr           <= '0;
      byte_send      <= 1'b0;
      byte_send_data <= 8'h00;
      reg_addr       <= '0;
      reg_wdata      <= 8'h00;
      reg_we         <= 1'b0;
      reg_re         <= 1'b0;
      busy           <= 1'b0;
      xfer_err       <= 1'b0;
    end else begin
      state          <= state_nx;
      addr           <= addr_nx;
      byte_send      <= byte_send_nx;
      byte_send_data <= byte_send_data_nx;
      reg_addr       <= reg_addr_nx;
      reg_wdata      <= reg_wdata_nx;
      reg_we         <= reg_we_nx;
      reg_re         <= reg_re_nx;
      busy           <= busy_nx;
      xfer_err       <= xfer_err_nx;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nx          = state;
    addr_nx           = addr;
    byte_send_nx      = byte_send;
    byte_send_data_nx = byte_send_data;
    reg_addr_nx       = addr;
    reg_wdata_nx      = reg_wdata;
    reg_we_nx         = 1'b0;
    reg_re_nx         = 1'b0;
    busy_nx           = 1'b1;
    xfer_err_nx       = xfer_err;

    if (state != S_IDLE && !ssel_active) begin
      // Chip-select dropped: abandon the transaction, and drop any byte that arrives in the same cycle.
      state_nx          = S_IDLE;
      addr_nx           = '0;
      byte_send_nx      = 1'b0;
      byte_send_data_nx = 8'h00;
      reg_addr_nx       = '0;
      reg_wdata_nx      = 8'h00;
      busy_nx           = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_nx           = '0;
          byte_send_nx      = 1'b0;
          byte_send_data_nx = 8'h00;
          reg_addr_nx       = '0;
          reg_wdata_nx      = 8'h00;
          busy_nx           = 1'b0;
          if (ssel_active) begin
            state_nx          = S_CMD;
            byte_send_nx      = 1'b1;
            byte_send_data_nx = IDLE_FILL;
            busy_nx           = 1'b1;
            xfer_err_nx       = 1'b0;
          end
        end
        S_CMD: begin
          if (byte_received) begin
            addr_nx     = cmd_addr;
            reg_addr_nx = cmd_addr;
            if (byte_received_data[7]) begin
              reg_re_nx    = 1'b1;
              byte_send_nx = 1'b0;
              state_nx     = S_RFETCH;
            end else begin
              state_nx = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (byte_received) begin
            reg_we_nx    = 1'b1;
            reg_wdata_nx = byte_received_data;
            reg_addr_nx  = addr;
            addr_nx      = addr_step;
          end
        end
        S_RFETCH: begin
          if (byte_received) begin
            xfer_err_nx = 1'b1;
          end
          // reg_re is still high in the first RFETCH cycle, so reg_rdata
          // becomes valid only in the cycle after that.
          if (!reg_re) begin
            byte_send_data_nx = reg_rdata;
            byte_send_nx      = 1'b1;
            state_nx          = S_READ;
          end
        end
        S_READ: begin
          if (byte_received) begin
            addr_nx      = addr_step;
            reg_addr_nx  = addr_step;
            reg_re_nx    = 1'b1;
            byte_send_nx = 1'b0;
            state_nx     = S_RFETCH;
          end
        end
        default: begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed bench for spi_cmd_ctrl. The expected values are
// written by hand. Where the SPI_CMD_AUTOINC_EN macro changes the behaviour,
// the bench selects the matching expected address or data.

module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ssel_active;
  logic       byte_received;
  logic [7:0] byte_received_data;
  logic       byte_send;
  logic [7:0] byte_send_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       xfer_err;

  logic [7:0] mem [0:127];

  int errors = 0;
  int checks = 0;

`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  spi_cmd_ctrl #(.ADDR_W(7), .IDLE_FILL(8'hFF)) dut (
    .clk                (clk),
    .reset              (reset),
    .ssel_active        (ssel_active),
    .byte_received      (byte_received),
    .byte_received_data (byte_received_data),
    .byte_send          (byte_send),
    .byte_send_data     (byte_send_data),
    .reg_addr           (reg_addr),
    .reg_wdata          (reg_wdata),
    .reg_we             (reg_we),
    .reg_re             (reg_re),
    .reg_rdata          (reg_rdata),
    .busy               (busy),
    .xfer_err           (xfer_err)
  );

  always #5 clk = ~clk;

  // Register file read port: data is valid one cycle after reg_re.
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Go to just after the next rising edge. Outputs registered at that edge are now stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_received      = 1'b1;
    byte_received_data = b;
    step();
    byte_received      = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_send"}, {31'd0, byte_send}, 32'd0);
    chk({tag, "_sdata"}, {24'd0, byte_send_data}, 32'd0);
    chk({tag, "_addr"}, {25'd0, reg_addr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, reg_wdata}, 32'd0);
    chk({tag, "_we_re"}, {30'd0, reg_we, reg_re}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, xfer_err}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h10] = 8'h3C;
    mem[7'h11] = 8'h4D;
    mem[7'h01] = 8'h5A;
    reg_rdata          = 8'h00;
    reset              = 1'b1;
    ssel_active        = 1'b0;
    byte_received      = 1'b0;
    byte_received_data = 8'h00;
    step();
    step();
    reset = 1'b0;
    step();
    chk_reset_outputs("rst");

    // Write burst: cmd 05, data A1, B2
    ssel_active = 1'b1;
    step();
    chk("cmd_busy", {31'd0, busy}, 32'd1);
    chk("cmd_send", {31'd0, byte_send}, 32'd1);
    chk("cmd_fill", {24'd0, byte_send_data}, 32'hFF);
    send_byte(8'h05);
    chk("wcmd_addr", {25'd0, reg_addr}, 32'h05);
    chk("wcmd_we_re", {30'd0, reg_we, reg_re}, 32'd0);
    step();
    send_byte(8'hA1);
    chk("w1_we", {31'd0, reg_we}, 32'd1);
    chk("w1_addr", {25'd0, reg_addr}, 32'h05);
    chk("w1_data", {24'd0, reg_wdata}, 32'hA1);
    chk("w1_fill", {24'd0, byte_send_data}, 32'hFF);
    step();
    chk("w1_we_off", {31'd0, reg_we}, 32'd0);
    chk("w1_adv", {25'd0, reg_addr}, AUTOINC ? 32'h06 : 32'h05);
    send_byte(8'hB2);
    chk("w2_we", {31'd0, reg_we}, 32'd1);
    chk("w2_addr", {25'd0, reg_addr}, AUTOINC ? 32'h06 : 32'h05);
    chk("w2_data", {24'd0, reg_wdata}, 32'hB2);
    chk("w2_send", {23'd0, byte_send, byte_send_data}, 32'h1FF);
    ssel_active = 1'b0;
    step();
    chk("w_end_busy", {31'd0, busy}, 32'd0);
    chk("w_end_send", {31'd0, byte_send}, 32'd0);

    // Read burst: cmd 90
    ssel_active = 1'b1;
    step();
    send_byte(8'h90);
    chk("r1_re", {31'd0, reg_re}, 32'd1);
    chk("r1_addr", {25'd0, reg_addr}, 32'h10);
    chk("r1_send_low", {31'd0, byte_send}, 32'd0);
    step();
    chk("r1_wait", {30'd0, byte_send, reg_re}, 32'd0);
    step();
    chk("r1_data", {23'd0, byte_send, byte_send_data}, 32'h13C);
    send_byte(8'h00);
    chk("r2_re", {31'd0, reg_re}, 32'd1);
    chk("r2_addr", {25'd0, reg_addr}, AUTOINC ? 32'h11 : 32'h10);
    step();
    step();
    chk("r2_data", {23'd0, byte_send, byte_send_data}, AUTOINC ? 32'h14D : 32'h13C);
    chk("r_noerr", {31'd0, xfer_err}, 32'd0);
    ssel_active = 1'b0;
    step();

    // Wrap at the top address
    ssel_active = 1'b1;
    step();
    send_byte(8'h7F);
    step();
    send_byte(8'h11);
    chk("wrap1", {24'd0, reg_we, reg_addr}, 32'hFF);
    step();
    send_byte(8'h22);
    chk("wrap2", {24'd0, reg_we, reg_addr}, AUTOINC ? 32'h80 : 32'hFF);
    ssel_active = 1'b0;
    step();

    // Chip-select drops in the same cycle as a byte in WRITE
    ssel_active = 1'b1;
    step();
    send_byte(8'h03);
    step();
    byte_received      = 1'b1;
    byte_received_data = 8'h55;
    ssel_active        = 1'b0;
    step();
    byte_received = 1'b0;
    chk("drop_we", {31'd0, reg_we}, 32'd0);
    chk("drop_busy", {31'd0, busy}, 32'd0);
    step();
    chk("drop_we2", {31'd0, reg_we}, 32'd0);

    // Overrun: byte in the first RFETCH cycle
    ssel_active = 1'b1;
    step();
    send_byte(8'h90);
    send_byte(8'h00);
    chk("ovr_err", {31'd0, xfer_err}, 32'd1);
    chk("ovr_re", {31'd0, reg_re}, 32'd0);
    step();
    chk("ovr_data", {23'd0, byte_send, byte_send_data}, 32'h13C);
    ssel_active = 1'b0;
    step();
    chk("ovr_sticky", {31'd0, xfer_err}, 32'd1);
    ssel_active = 1'b1;
    step();
    chk("ovr_clear", {31'd0, xfer_err}, 32'd0);
    ssel_active = 1'b0;
    step();

    // Reset in READ, then read cmd 81
    ssel_active = 1'b1;
    step();
    send_byte(8'h90);
    step();
    step();
    chk("pre_rst_send", {31'd0, byte_send}, 32'd1);
    reset       = 1'b1;
    ssel_active = 1'b0;
    step();
    chk_reset_outputs("mid_rst");
    reset = 1'b0;
    step();
    ssel_active = 1'b1;
    step();
    send_byte(8'h81);
    chk("post_re", {24'd0, reg_re, reg_addr}, 32'h81);
    step();
    step();
    chk("post_data", {23'd0, byte_send, byte_send_data}, 32'h15A);
    ssel_active = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
